// File: rtl/bmu_cntunit.sv
// Two-stage bit-count unit (cpop/clz/ctz). S1 registers the count mask and S2 registers its popcount, so the result is valid two cycles after the operand is presented.
// Valid/ready backpressure: a stalled S2 holds its result and S1 holds its mask, and Flush kills both stages.
module bmu_cntunit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       Op,
    input  logic             W,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] LO_MASK = WIDTH'(64'h0000_0000_FFFF_FFFF);

    logic             s1_vld;
    logic             s2_vld;
    logic [WIDTH-1:0] s1_p;
    logic             s1_en;
    logic             s2_en;
    logic             accept;

    logic             word;
    logic [WIDTH-1:0] eff_mask;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] e_dec;
    logic [WIDTH-1:0] p_ctz;
    logic [WIDTH-1:0] p_clz;
    logic [WIDTH-1:0] p_next;
    logic             clz_seen;
    logic [CW-1:0]    pop;

    assign s2_en    = !s2_vld || OutReady;
    assign s1_en    = !s1_vld || s2_en;
    assign InReady  = s1_en && !Flush;
    assign accept   = InValid && InReady;
    assign OutValid = s2_vld;

    // Word mode is meaningful only on a 64-bit unit; the mask confines every operation to the low word.
    assign word     = W && (WIDTH == 64);
    assign eff_mask = word ? LO_MASK : '1;
    assign e        = A & eff_mask;
    assign e_dec    = e - WIDTH'(1);
    assign p_ctz    = ~e & e_dec & eff_mask;

    // Leading-zero mask: a bit survives only while no set bit has been seen above it.
    always_comb begin
        clz_seen = 1'b0;
        p_clz    = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            clz_seen = clz_seen | e[i];
            p_clz[i] = ~clz_seen;
        end
        p_clz = p_clz & eff_mask;
    end

    always_comb begin
        p_next = '0;
        case (Op)
            2'b00:   p_next = e;
            2'b01:   p_next = p_clz;
            2'b10:   p_next = p_ctz;
            default: p_next = '0;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + CW'(s1_p[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_p   <= '0;
            Result <= '0;
        end else begin
            if (Flush) begin
                s1_vld <= 1'b0;
                s2_vld <= 1'b0;
            end else begin
                if (s1_en) s1_vld <= accept;
                if (s2_en) s2_vld <= s1_vld;
            end
            if (accept) s1_p <= p_next;
            if (s2_en && s1_vld) Result <= WIDTH'(pop);
        end
    end

endmodule

// File: doc/bmu_cntunit.md
BMU_CNTUNIT -- requirements
Module: bmu_cntunit

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand width; legal values 32 and 64.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: InValid  input  1  upstream operand valid.
REQ-005 SHALL have port: InReady  output  1  unit accepts operand this cycle.
REQ-006 SHALL have port: A  input  WIDTH  source operand.
REQ-007 SHALL have port: Op  input  2  00 cpop, 01 clz, 10 ctz, 11 reserved.
REQ-008 SHALL have port: W  input  1  word mode: operate on A[31:0] only; ignored when WIDTH=32.
REQ-009 SHALL have port: Flush  input  1  synchronous kill of all in-flight operations.
REQ-010 SHALL have port: OutValid  output  1  Result valid.
REQ-011 SHALL have port: OutReady  input  1  downstream accepts Result.
REQ-012 SHALL have port: Result  output  WIDTH  count, zero-extended.

Function
REQ-013 SHALL be a two-stage pipeline: S1 registers the pre-processed mask P; S2 registers Result = zero-extended population count of P.
REQ-014 Operand transfer SHALL occur on an edge where InValid & InReady; Result transfer on an edge where OutValid & OutReady.
REQ-015 Enables: s2_en = !S2Valid | OutReady; s1_en = !S1Valid | s2_en; InReady = s1_en & !Flush.
REQ-016 Latency SHALL be 2 cycles from accept edge to OutValid with no backpressure; throughput SHALL be one operation per cycle.
REQ-017 Effective operand E = A when W=0 or WIDTH=32; E = {zeros, A[31:0]} when W=1 and WIDTH=64.
REQ-018 cpop: P = E.
REQ-019 ctz: P = ~E & (E - 1) over the effective width (32 bits in word mode); E=0 yields 32 (word) or WIDTH.
REQ-020 clz: P[i] = 1 iff no bit of E at position >= i within the effective width is set; E=0 yields 32 (word) or WIDTH.
REQ-021 Op=11 SHALL complete normally through the handshake with Result = 0.
REQ-022 While OutValid & !OutReady, Result, OutValid and S1 contents SHALL hold stable; an S1 entry SHALL NOT overwrite S2.
REQ-023 S2 SHALL load from S1 on s2_en; S2Valid next = S1Valid when s2_en, else hold; S1Valid next = accept when s1_en, else hold.
REQ-024 Simultaneous OutReady and accept with both stages full SHALL advance both stages with no bubble and no loss.
REQ-025 Flush SHALL clear S1Valid and S2Valid on the same edge, override any concurrent accept, and deassert InReady combinationally; Result data need not clear.
REQ-026 Result of maximum value (WIDTH) SHALL fit: popcount width $clog2(WIDTH)+1 bits, upper bits zero.
REQ-027 No combinational path SHALL exist from A/Op/W to OutValid or Result.

Reset
REQ-028 On reset_n low, S1Valid, S2Valid, OutValid SHALL go to 0 immediately (asynchronous) and stored P and Result to 0.
REQ-029 InReady SHALL be 1 during and after reset when Flush=0 (pipeline empty).
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations; first OutValid after release SHALL be 2 cycles after a new accept.

Verification
REQ-031 WIDTH=64, OutReady=1: accept cpop A=0xF0F0_0000_0000_0001 -> 2 cycles later OutValid=1, Result=9.
REQ-032 Back-to-back clz A=0x0000_0000_0000_8000, ctz A=0x0000_0000_0000_8000, clz W=1 A=0xFFFF_FFFF_0000_0001 -> Results 48, 15, 31 on three consecutive cycles.
REQ-033 Zero operands: clz A=0 -> 64; ctz W=1 A=0xFFFF_FFFF_0000_0000 -> 32; Op=11 any A -> 0.
REQ-034 Backpressure: OutReady=0 with InValid=1 for 4 cycles -> exactly 2 accepted, InReady=0 thereafter, Result stable; OutReady=1 drains both in order, no loss or duplication.
REQ-035 Flush with both stages full and InValid=1 -> next cycle OutValid=0, nothing accepted that edge; next accept appears 2 cycles later.
REQ-036 reset_n pulsed low mid-stream (asynchronous to clk) -> OutValid=0 immediately, Result=0, InReady=1 after release.
